paddle_motion: RTL and testbench

//  Converts held up/down key levels from the PS/2 decoder into the racket's vertical position for the
//  VGA renderer. Updates once per video frame on frame_tick, accelerates while a key is held and

---
 rtl/paddle_motion.sv | 140 ++++++++++++++
 tb/tb_paddle_motion.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion.sv
// paddle_motion: turns held up/down key levels into the racket top line, accelerating and clamped to the visible area.
// Latency: keys pass a 2-flop synchroniser; all outputs are registered and valid the cycle after frame_tick.
// Backpressure: none; state advances only on frame_tick. Optional macro PADDLE_AUTO_EN adds ball-tracking auto mode.
module paddle_motion #(
   parameter int V_RES        = 480,
   parameter int PADDLE_H     = 64,
   parameter int Y_WIDTH      = 10,
   parameter int SPEED_MIN    = 1,
   parameter int SPEED_MAX    = 8,
   parameter int ACCEL_FRAMES = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               frame_tick,
   input  logic               up_in,
   input  logic               down_in,
`ifdef PADDLE_AUTO_EN
   input  logic               auto_mode,
   input  logic [Y_WIDTH-1:0] ball_y,
`endif
   output logic [Y_WIDTH-1:0] paddle_y,
   output logic [3:0]         speed,
   output logic               moving,
   output logic               at_top,
   output logic               at_bottom
);

   localparam int HW = $clog2(ACCEL_FRAMES + 1);
   localparam logic [Y_WIDTH:0]   Y_MAX    = (Y_WIDTH+1)'(V_RES - PADDLE_H);
   localparam logic [Y_WIDTH-1:0] Y_RESET  = Y_WIDTH'((V_RES - PADDLE_H) / 2);
   localparam logic [3:0]         SPD_MIN  = 4'(SPEED_MIN);
   localparam logic [3:0]         SPD_MAX  = 4'(SPEED_MAX);
   localparam logic [HW-1:0]      ACC_LAST = HW'(ACCEL_FRAMES);

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

   state_t            state;
   state_t            req_state;
   logic [HW-1:0]     hold_cnt;
   logic              up_meta, up_sync, dn_meta, dn_sync;
   logic              up_req, dn_req;
   logic [3:0]        step;
   logic [3:0]        nxt_speed;
   logic [HW-1:0]     nxt_hold;
   logic [Y_WIDTH-1:0] nxt_y;
   logic [Y_WIDTH:0]  y_w, step_w, sum_dn;
   logic [Y_WIDTH-1:0] diff_up;

`ifdef PADDLE_AUTO_EN
   localparam logic [Y_WIDTH:0] HALF_H = (Y_WIDTH+1)'(PADDLE_H / 2);
   localparam logic [Y_WIDTH:0] DEAD   = (Y_WIDTH+1)'(4);
   logic [Y_WIDTH:0] centre, ball_w;
`endif

   // Two-flop synchronisers for the asynchronous key levels; run every clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         up_meta <= 1'b0;
         up_sync <= 1'b0;
         dn_meta <= 1'b0;
         dn_sync <= 1'b0;
      end else begin
         up_meta <= up_in;
         up_sync <= up_meta;
         dn_meta <= down_in;
         dn_sync <= dn_meta;
      end
   end

   // Requested direction, then speed/hold/position update for this frame.
   always_comb begin
      up_req = up_sync;
      dn_req = dn_sync;
`ifdef PADDLE_AUTO_EN
      centre = {1'b0, paddle_y} + HALF_H;
      ball_w = {1'b0, ball_y};
      if (auto_mode) begin
         // centre >= HALF_H, so comparing ball+4 against centre avoids underflow
         up_req = (ball_w + DEAD) < centre;
         dn_req = ball_w > (centre + DEAD);
      end
`endif
      req_state = IDLE;
      if (up_req && !dn_req)      req_state = MOVE_UP;
      else if (dn_req && !up_req) req_state = MOVE_DOWN;

      step      = 4'd0;
      nxt_speed = speed;
      nxt_hold  = hold_cnt;
      if (req_state == IDLE) begin
         nxt_speed = SPD_MIN;
         nxt_hold  = '0;
      end else if (req_state != state) begin
         // entry or reversal restarts from the slowest speed
         step      = SPD_MIN;
         nxt_speed = SPD_MIN;
         nxt_hold  = HW'(1);
      end else begin
         step = speed;
         if (hold_cnt + 1'b1 == ACC_LAST) begin
            nxt_speed = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'd1;
            nxt_hold  = '0;
         end else begin
            nxt_hold  = hold_cnt + 1'b1;
         end
      end

      y_w     = {1'b0, paddle_y};
      step_w  = (Y_WIDTH+1)'(step);
      sum_dn  = y_w + step_w;
      diff_up = paddle_y - step_w[Y_WIDTH-1:0];
      nxt_y   = paddle_y;
      if (req_state == MOVE_UP)
         nxt_y = (y_w >= step_w) ? diff_up : '0;
      else if (req_state == MOVE_DOWN)
         nxt_y = (sum_dn > Y_MAX) ? Y_MAX[Y_WIDTH-1:0] : sum_dn[Y_WIDTH-1:0];
   end

   // FSM and registered outputs; everything holds between frame ticks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         paddle_y  <= Y_RESET;
         speed     <= SPD_MIN;
         hold_cnt  <= '0;
         moving    <= 1'b0;
         at_top    <= 1'b0;
         at_bottom <= 1'b0;
      end else if (frame_tick) begin
         state     <= req_state;
         paddle_y  <= nxt_y;
         speed     <= nxt_speed;
         hold_cnt  <= nxt_hold;
         moving    <= (req_state != IDLE);
         at_top    <= (nxt_y == '0);
         at_bottom <= ({1'b0, nxt_y} == Y_MAX);
      end
   end

endmodule

// File: tb/tb_paddle_motion.sv
// tb_paddle_motion: randomized and directed frames against an integer model of the paddle rules.
// Latency: outputs checked one clock after each frame tick.
// Backpressure: none.
module tb_paddle_motion;

   localparam int YMAX = 416;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       up_in = 1'b0;
   logic       down_in = 1'b0;
   logic [9:0] paddle_y;
   logic [3:0] speed;
   logic       moving, at_top, at_bottom;
`ifdef PADDLE_AUTO_EN
   logic       auto_mode = 1'b0;
   logic [9:0] ball_y = 10'd0;
`endif

   paddle_motion dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .up_in      (up_in),
      .down_in    (down_in),
`ifdef PADDLE_AUTO_EN
      .auto_mode  (auto_mode),
      .ball_y     (ball_y),
`endif
      .paddle_y   (paddle_y),
      .speed      (speed),
      .moving     (moving),
      .at_top     (at_top),
      .at_bottom  (at_bottom)
   );

   always #10 clock = ~clock;

   wire [16:0] obs = {paddle_y, speed, moving, at_top, at_bottom};

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: position, speed, frames held at current speed, direction (-1/0/+1)
   int m_y, m_speed, m_hold, m_dir;

   task automatic model_reset();
      m_y = 208; m_speed = 1; m_hold = 0; m_dir = 0;
   endtask

   function automatic logic [16:0] exp_vec();
      return {10'(m_y), 4'(m_speed), (m_dir != 0), (m_y == 0), (m_y == YMAX)};
   endfunction

   task automatic set_keys(input logic u, input logic d);
      @(negedge clock);
      up_in = u;
      down_in = d;
      repeat (3) @(negedge clock);
   endtask

   // one frame tick, then advance the model from the key levels held during it
   task automatic tick();
      int dir, step;
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      dir = (up_in && !down_in) ? -1 : (down_in && !up_in) ? 1 : 0;
      step = 0;
      if (dir == 0) begin
         m_speed = 1; m_hold = 0;
      end else if (dir != m_dir) begin
         step = 1; m_speed = 1; m_hold = 1;
      end else begin
         step = m_speed;
         if (m_hold + 1 == 4) begin
            m_hold = 0;
            m_speed = (m_speed + 1 > 8) ? 8 : m_speed + 1;
         end else begin
            m_hold = m_hold + 1;
         end
      end
      m_y = m_y + dir * step;
      if (m_y < 0) m_y = 0;
      if (m_y > YMAX) m_y = YMAX;
      m_dir = dir;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_state: got %h want %h", obs, exp_vec());
      else n_pass++;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL idle_tick %0d: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_accel_up();
      set_keys(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL accel_up %0d: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (paddle_y !== 10'd202 || speed !== 4'd2)
         $display("FAIL accel_up_final: got y=%0d speed=%0d want y=202 speed=2", paddle_y, speed);
      else n_pass++;
   endtask

   task automatic test_top_clamp();
      for (int i = 0; i < 60; i++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL top_clamp %0d: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (paddle_y !== 10'd0 || at_top !== 1'b1 || moving !== 1'b1 || speed !== 4'd8)
         $display("FAIL top_final: got y=%0d top=%0b mv=%0b spd=%0d want 0 1 1 8", paddle_y, at_top, moving, speed);
      else n_pass++;
   endtask

   task automatic test_both_keys_no_tick();
      set_keys(1'b1, 1'b1);
      tick();
      n_checks++;
      if (obs !== exp_vec() || moving !== 1'b0) $display("FAIL both_keys: got %h want %h", obs, exp_vec());
      else n_pass++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         up_in = 1'($urandom);
         down_in = 1'($urandom);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL no_tick_hold: got %h want %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_bottom_clamp();
      set_keys(1'b0, 1'b1);
      for (int i = 0; i < 80; i++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL bottom_clamp %0d: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (paddle_y !== 10'd416 || at_bottom !== 1'b1 || moving !== 1'b1)
         $display("FAIL bottom_final: got y=%0d bot=%0b mv=%0b want 416 1 1", paddle_y, at_bottom, moving);
      else n_pass++;
   endtask

   task automatic test_reversal();
      set_keys(1'b1, 1'b0);
      tick();
      n_checks++;
      if (obs !== exp_vec() || paddle_y !== 10'd415 || speed !== 4'd1)
         $display("FAIL reversal: got y=%0d spd=%0d want y=415 spd=1", paddle_y, speed);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0)
            set_keys(1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 4)) @(negedge clock);
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL random %0d: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      set_keys(1'b1, 1'b0);
      repeat (3) tick();
      @(negedge clock);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL async_reset: got %h want %h", obs, exp_vec());
      else n_pass++;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      tick();
      n_checks++;
      if (obs !== exp_vec() || paddle_y !== 10'd207 || speed !== 4'd1)
         $display("FAIL resume_after_reset: got y=%0d spd=%0d want y=207 spd=1", paddle_y, speed);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_accel_up();
      test_top_clamp();
      test_both_keys_no_tick();
      test_bottom_clamp();
      test_reversal();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
